block_plotter: RTL and testbench

//   Parametrised rectangular block rasteriser for the VGA plotting path.
//   On a start handshake it latches an origin, colour and mode, then emits one pixel
//   per clock over a BLK_W x BLK_H rectangle. Pixels are emitted in row-major order.

---
 rtl/block_plotter_pkg.sv | 32 +++
 rtl/block_plotter_xy_scan_counter.sv | 57 +++++
 rtl/block_plotter.sv | 131 +++++++++++++
 tb/tb_block_plotter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/block_plotter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blk_pkg
//  Description : Shared state encoding, default geometry and helpers for the
//                rectangular block plotter.
//  Revision    : 1.0 - initial release
// ============================================================================
package blk_pkg;

   // Plotter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } blk_state_e;

   // Default screen and block geometry
   localparam int c_DEF_X_W      = 8;
   localparam int c_DEF_Y_W      = 7;
   localparam int c_DEF_C_W      = 3;
   localparam int c_DEF_SCREEN_W = 160;
   localparam int c_DEF_SCREEN_H = 120;
   localparam int c_DEF_BLK_W    = 4;
   localparam int c_DEF_BLK_H    = 4;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : blk_pkg
`default_nettype wire

// File: rtl/block_plotter_xy_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : xy_scan_counter
//  Description : Row-major column/row counter for a BLK_W x BLK_H block scan.
//                last flags the final pixel of the block.
//  Revision    : 1.0 - initial release
// ============================================================================
module xy_scan_counter
   import blk_pkg::*;
#(
   parameter int BLK_W = c_DEF_BLK_W,
   parameter int BLK_H = c_DEF_BLK_H,
   localparam int CX_W = cnt_width(BLK_W),
   localparam int CY_W = cnt_width(BLK_H)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            clr,
   input  logic            en,
   output logic [CX_W-1:0] cx,
   output logic [CY_W-1:0] cy,
   output logic            last
);

   localparam logic [CX_W-1:0] c_CX_MAX = CX_W'(BLK_W - 1);
   localparam logic [CY_W-1:0] c_CY_MAX = CY_W'(BLK_H - 1);

   logic [CX_W-1:0] r_cx;
   logic [CY_W-1:0] r_cy;
   logic            w_row_end;

   assign w_row_end = (r_cx == c_CX_MAX);

   // Advance column first, wrapping into the next row at the row end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cx <= '0;
         r_cy <= '0;
      end else if (clr) begin
         r_cx <= '0;
         r_cy <= '0;
      end else if (en) begin
         if (w_row_end) begin
            r_cx <= '0;
            r_cy <= r_cy + CY_W'(1);
         end else begin
            r_cx <= r_cx + CX_W'(1);
         end
      end
   end

   assign cx   = r_cx;
   assign cy   = r_cy;
   assign last = w_row_end && (r_cy == c_CY_MAX);

endmodule : xy_scan_counter
`default_nettype wire

// File: rtl/block_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : block_plotter
//  Description : Rectangular block rasteriser. Latches origin/colour/mode on
//                start, emits one clipped pixel per clock in row-major order,
//                then pulses done and publishes the covered column span.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_plotter
   import blk_pkg::*;
#(
   parameter int X_W       = c_DEF_X_W,
   parameter int Y_W       = c_DEF_Y_W,
   parameter int C_W       = c_DEF_C_W,
   parameter int BLK_W     = c_DEF_BLK_W,
   parameter int BLK_H     = c_DEF_BLK_H,
   parameter int SCREEN_W  = c_DEF_SCREEN_W,
   parameter int SCREEN_H  = c_DEF_SCREEN_H,
   parameter int BG_COLOUR = 0
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic           erase,
   input  logic [X_W-1:0] x_in,
   input  logic [Y_W-1:0] y_in,
   input  logic [C_W-1:0] colour_in,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [C_W-1:0] colour_out,
   output logic           plot,
   output logic           busy,
   output logic           done,
   output logic [X_W:0]   span_start,
   output logic [X_W:0]   span_end
);

   localparam int CX_W = cnt_width(BLK_W);
   localparam int CY_W = cnt_width(BLK_H);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_DRAW = ST_DRAW;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]     r_state;
   logic [X_W-1:0] r_x0;
   logic [Y_W-1:0] r_y0;
   logic [C_W-1:0] r_colour;
   logic           r_erase;
   logic [X_W:0]   r_span_start;
   logic [X_W:0]   r_span_end;

   logic [CX_W-1:0] w_cx;
   logic [CY_W-1:0] w_cy;
   logic            w_last;
   logic            w_accept;
   logic            w_drawing;
   logic [X_W:0]    w_sum_x;
   logic [Y_W:0]    w_sum_y;
   logic            w_clipped;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_drawing = (r_state == S_DRAW);

   xy_scan_counter #(
      .BLK_W (BLK_W),
      .BLK_H (BLK_H)
   ) u_scan (
      .clk    (clk),
      .resetn (resetn),
      .clr    (w_accept),
      .en     (w_drawing),
      .cx     (w_cx),
      .cy     (w_cy),
      .last   (w_last)
   );

   // Sequencing, input latching on accept and span publication on completion
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_x0         <= '0;
         r_y0         <= '0;
         r_colour     <= '0;
         r_erase      <= 1'b0;
         r_span_start <= '0;
         r_span_end   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x0     <= x_in;
                  r_y0     <= y_in;
                  r_colour <= colour_in;
                  r_erase  <= erase;
                  r_state  <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_last) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_span_start <= {1'b0, r_x0};
               r_span_end   <= {1'b0, r_x0} + (X_W+1)'(BLK_W - 1);
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Sums kept one bit wider so off-screen pixels are clipped instead of wrapping
   assign w_sum_x   = {1'b0, r_x0} + (X_W+1)'(w_cx);
   assign w_sum_y   = {1'b0, r_y0} + (Y_W+1)'(w_cy);
   assign w_clipped = (w_sum_x >= (X_W+1)'(SCREEN_W)) || (w_sum_y >= (Y_W+1)'(SCREEN_H));

   assign x_out      = w_sum_x[X_W-1:0];
   assign y_out      = w_sum_y[Y_W-1:0];
   assign colour_out = r_erase ? C_W'(BG_COLOUR) : r_colour;
   assign plot       = w_drawing && !w_clipped;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign span_start = r_span_start;
   assign span_end   = r_span_end;

endmodule : block_plotter
`default_nettype wire

// File: tb/tb_block_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_plotter
//  Description : Self-checking bench for block_plotter (4x4 default build and
//                a 1x1 build) against a pixel-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_plotter;

   localparam int BW = 4;
   localparam int BH = 4;
   localparam int NPIX = BW * BH;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       start1 = 1'b0;
   logic       erase = 1'b0;
   logic [7:0] x_in = '0;
   logic [6:0] y_in = '0;
   logic [2:0] colour_in = '0;

   logic [7:0] x_out, x_out1;
   logic [6:0] y_out, y_out1;
   logic [2:0] colour_out, colour_out1;
   logic       plot, plot1, busy, busy1, done, done1;
   logic [8:0] span_start, span_end, span_start1, span_end1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   block_plotter dut (
      .clk(clk), .resetn(resetn), .start(start), .erase(erase),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
      .plot(plot), .busy(busy), .done(done),
      .span_start(span_start), .span_end(span_end)
   );

   block_plotter #(.BLK_W(1), .BLK_H(1)) dut1 (
      .clk(clk), .resetn(resetn), .start(start1), .erase(erase),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .x_out(x_out1), .y_out(y_out1), .colour_out(colour_out1),
      .plot(plot1), .busy(busy1), .done(done1),
      .span_start(span_start1), .span_end(span_end1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Draw one block and compare the plotted pixel list, done timing and span
   task automatic do_block(input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic e, input bit hold);
      logic [17:0] exp_q[$];
      logic [17:0] got_q[$];
      for (int r = 0; r < BH; r++) begin
         for (int q = 0; q < BW; q++) begin
            int px;
            int py;
            px = int'(x) + q;
            py = int'(y) + r;
            if (px < 160 && py < 120)
               exp_q.push_back({8'(px), 7'(py), (e ? 3'd0 : c)});
         end
      end
      @(negedge clk);
      start = 1'b1; x_in = x; y_in = y; colour_in = c; erase = e;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      for (int k = 1; k <= NPIX + 1; k++) begin
         if (hold) begin
            x_in = 8'($urandom); y_in = 7'($urandom);
            colour_in = 3'($urandom); erase = 1'($urandom);
         end
         @(negedge clk);
         if (plot) got_q.push_back({x_out, y_out, colour_out});
         chk("busy_draw", 32'(busy), 32'd1);
         chk("done_timing", 32'(done), 32'(k == NPIX + 1));
         if (k == NPIX + 1) chk("plot_in_done", 32'(plot), 32'd0);
      end
      chk("pixel_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("pixel", 32'(got_q[i]), 32'(exp_q[i]));
      if (hold) begin
         x_in = 8'd50; y_in = 7'd30; colour_in = 3'd2; erase = 1'b0;
      end
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("span_start", 32'(span_start), 32'(x));
      chk("span_end", 32'(span_end), int'(x) + BW - 1);
      if (hold) begin
         @(negedge clk);
         chk("reaccept_busy", 32'(busy), 32'd1);
         chk("reaccept_plot", 32'(plot), 32'd1);
         chk("reaccept_x", 32'(x_out), 32'd50);
         chk("reaccept_y", 32'(y_out), 32'd30);
         start = 1'b0;
         for (int w = 0; w < NPIX + 4 && busy; w++) @(negedge clk);
         chk("drain", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_plot", 32'(plot), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_span_start", 32'(span_start), 32'd0);
      chk("rst_span_end", 32'(span_end), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      resetn = 1'b1;

      // Directed cases: plain draw, erase at origin, clipped corner, held start
      do_block(8'd10, 7'd20, 3'd5, 1'b0, 1'b0);
      do_block(8'd0, 7'd0, 3'd6, 1'b1, 1'b0);
      do_block(8'd158, 7'd118, 3'd3, 1'b0, 1'b0);
      do_block(8'd70, 7'd60, 3'd1, 1'b0, 1'b1);

      // Reset during the seventh pixel aborts the block
      @(negedge clk);
      start = 1'b1; x_in = 8'd40; y_in = 7'd40; colour_in = 3'd4; erase = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pix7_plot", 32'(plot), 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_plot", 32'(plot), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_span_start", 32'(span_start), 32'd0);
      chk("abort_span_end", 32'(span_end), 32'd0);
      resetn = 1'b1;
      for (int k = 0; k < NPIX + 2; k++) begin
         @(negedge clk);
         chk("no_done_after_abort", 32'(done), 32'd0);
      end
      do_block(8'd40, 7'd40, 3'd4, 1'b0, 1'b0);

      // Randomised blocks, half of them pushed against the screen edges
      for (int n = 0; n < 12; n++) begin
         logic [7:0] rx;
         logic [6:0] ry;
         if (n % 2 == 0) begin
            rx = 8'($urandom_range(150, 165));
            ry = 7'($urandom_range(112, 127));
         end else begin
            rx = 8'($urandom);
            ry = 7'($urandom);
         end
         do_block(rx, ry, 3'($urandom), 1'($urandom), 1'b0);
      end

      // 1x1 build: one pixel, then done on the following cycle
      @(negedge clk);
      start1 = 1'b1; x_in = 8'd77; y_in = 7'd33; colour_in = 3'd7; erase = 1'b0;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      chk("b1_plot", 32'(plot1), 32'd1);
      chk("b1_x", 32'(x_out1), 32'd77);
      chk("b1_y", 32'(y_out1), 32'd33);
      chk("b1_colour", 32'(colour_out1), 32'd7);
      chk("b1_done_early", 32'(done1), 32'd0);
      @(negedge clk);
      chk("b1_done", 32'(done1), 32'd1);
      chk("b1_plot_done", 32'(plot1), 32'd0);
      @(negedge clk);
      chk("b1_busy", 32'(busy1), 32'd0);
      chk("b1_span_start", 32'(span_start1), 32'd77);
      chk("b1_span_end", 32'(span_end1), 32'd77);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_block_plotter
`default_nettype wire
